// File: rtl/bcdtime_load.sv
// bcdtime_load: producer side of the bcdtime set interface.
//
// Takes a binary seconds-of-day label for the second currently elapsing,
// converts label+1 to BCD by iterative subtraction, then arms and fires `set`
// combinationally on the next tsc_1pps so the counters load on the PPS edge.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   tsc_1pps     one-cycle pulse at each second boundary
//   tsc_1ppms    one-cycle pulse each millisecond
//   req          one-cycle load request (ignored while busy)
//   sod          seconds-of-day, valid range 0..86399
//   busy         high in any state other than idle
//   set          load strobe (same cycle as the PPS pulse)
//   set_time     BCD load value, nibbles MSB..LSB:
//                t_10h t_1h t_10m t_1m t_10s t_1s t_100ms t_10ms t_1ms
//   done         one-cycle pulse coincident with set
//   err_range    pulse the cycle after a req with sod > 86399
//   err_late     pulse in the cycle PPS arrives mid-conversion
//   err_timeout  pulse on the ms tick that exhausts the arming window
module bcdtime_load #(
  parameter int unsigned SOD_W      = 17,
  parameter int unsigned TIMEOUT_MS = 2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tsc_1pps,
  input  logic             tsc_1ppms,
  input  logic             req,
  input  logic [SOD_W-1:0] sod,
  output logic             busy,
  output logic             set,
  output logic [35:0]      set_time,
  output logic             done,
  output logic             err_range,
  output logic             err_late,
  output logic             err_timeout
);

  localparam int unsigned CntW = $clog2(TIMEOUT_MS + 1);
  localparam logic [SOD_W-1:0] MaxSod = SOD_W'(86399);

  typedef enum logic [2:0] {
    StIdle, StHours, StMins, StSplitH, StSplitM, StSplitS, StArmed
  } state_e;

  state_e            state_q, state_d;
  logic [SOD_W-1:0]  v_q, v_d;        // running remainder; ends as seconds
  logic [4:0]        hrs_q, hrs_d;    // hours, then units-of-hours
  logic [5:0]        mins_q, mins_d;  // minutes, then units-of-minutes
  logic [3:0]        h10_q, h10_d;
  logic [3:0]        m10_q, m10_d;
  logic [3:0]        s10_q, s10_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [35:0]       set_time_q, set_time_d;
  logic              err_range_q, err_range_d;
  logic              converting;

  assign converting = (state_q == StHours) || (state_q == StMins) ||
                      (state_q == StSplitH) || (state_q == StSplitM) ||
                      (state_q == StSplitS);

  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    hrs_d       = hrs_q;
    mins_d      = mins_q;
    h10_d       = h10_q;
    m10_d       = m10_q;
    s10_d       = s10_q;
    cnt_d       = cnt_q;
    set_time_d  = set_time_q;
    err_range_d = 1'b0;
    set         = 1'b0;
    done        = 1'b0;
    err_late    = 1'b0;
    err_timeout = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (sod > MaxSod) begin
            err_range_d = 1'b1;
          end else begin
            // Load the label of the second that starts at the next PPS.
            v_d     = (sod == MaxSod) ? '0 : sod + SOD_W'(1);
            hrs_d   = '0;
            mins_d  = '0;
            h10_d   = '0;
            m10_d   = '0;
            s10_d   = '0;
            state_d = StHours;
          end
        end
      end
      StHours: begin
        if (v_q >= SOD_W'(3600)) begin
          v_d   = v_q - SOD_W'(3600);
          hrs_d = hrs_q + 5'd1;
        end else begin
          state_d = StMins;
        end
      end
      StMins: begin
        if (v_q >= SOD_W'(60)) begin
          v_d    = v_q - SOD_W'(60);
          mins_d = mins_q + 6'd1;
        end else begin
          state_d = StSplitH;
        end
      end
      StSplitH: begin
        if (hrs_q >= 5'd10) begin
          hrs_d = hrs_q - 5'd10;
          h10_d = h10_q + 4'd1;
        end else begin
          state_d = StSplitM;
        end
      end
      StSplitM: begin
        if (mins_q >= 6'd10) begin
          mins_d = mins_q - 6'd10;
          m10_d  = m10_q + 4'd1;
        end else begin
          state_d = StSplitS;
        end
      end
      StSplitS: begin
        if (v_q >= SOD_W'(10)) begin
          v_d   = v_q - SOD_W'(10);
          s10_d = s10_q + 4'd1;
        end else begin
          set_time_d = {h10_q, hrs_q[3:0], m10_q, mins_q[3:0], s10_q, v_q[3:0], 12'h000};
          cnt_d      = '0;
          state_d    = StArmed;
        end
      end
      StArmed: begin
        // PPS takes priority over a coincident final ms tick.
        if (tsc_1pps) begin
          set     = 1'b1;
          done    = 1'b1;
          state_d = StIdle;
        end else if (tsc_1ppms) begin
          if (cnt_q == CntW'(TIMEOUT_MS - 1)) begin
            err_timeout = 1'b1;
            state_d     = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A PPS during conversion means the label is stale; drop it unloaded.
    if (converting && tsc_1pps) begin
      err_late   = 1'b1;
      set_time_d = set_time_q;
      state_d    = StIdle;
    end

    // Suppress strobes while reset is being sampled.
    if (rst) begin
      set         = 1'b0;
      done        = 1'b0;
      err_late    = 1'b0;
      err_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      v_q         <= '0;
      hrs_q       <= '0;
      mins_q      <= '0;
      h10_q       <= '0;
      m10_q       <= '0;
      s10_q       <= '0;
      cnt_q       <= '0;
      set_time_q  <= '0;
      err_range_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      hrs_q       <= hrs_d;
      mins_q      <= mins_d;
      h10_q       <= h10_d;
      m10_q       <= m10_d;
      s10_q       <= s10_d;
      cnt_q       <= cnt_d;
      set_time_q  <= set_time_d;
      err_range_q <= err_range_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign set_time  = set_time_q;
  assign err_range = err_range_q;

endmodule

// File: tb/tb_bcdtime_load.sv
module tb_bcdtime_load;

  logic        clk = 1'b0;
  logic        rst;
  logic        tsc_1pps;
  logic        tsc_1ppms;
  logic        req;
  logic [16:0] sod;
  logic        busy;
  logic        set;
  logic [35:0] set_time;
  logic        done;
  logic        err_range;
  logic        err_late;
  logic        err_timeout;

  int tests = 0;
  int fails = 0;

  bcdtime_load #(
    .SOD_W     (17),
    .TIMEOUT_MS(2000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tsc_1pps   (tsc_1pps),
    .tsc_1ppms  (tsc_1ppms),
    .req        (req),
    .sod        (sod),
    .busy       (busy),
    .set        (set),
    .set_time   (set_time),
    .done       (done),
    .err_range  (err_range),
    .err_late   (err_late),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Advance to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_req(input logic [16:0] v);
    req = 1'b1;
    sod = v;
    cyc();
    req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tsc_1pps = 1'b0;
    tsc_1ppms = 1'b0;
    req = 1'b0;
    sod = '0;
    cyc();
    cyc();
    #1;
    tests++;
    if ({busy, set, done, err_range, err_late, err_timeout} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 000000",
               {busy, set, done, err_range, err_late, err_timeout});
    end
    tests++;
    if (set_time !== 36'h0) begin
      fails++;
      $display("FAIL reset_set_time: got %h want 000000000", set_time);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_sod0();
    bit saw_set = 1'b0;
    do_req(17'd0);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL sod0_busy: got %b want 1", busy);
    end
    for (int i = 0; i < 2000; i++) begin
      #1;
      if (set) saw_set = 1'b1;
      cyc();
    end
    tests++;
    if (saw_set !== 1'b0) begin
      fails++;
      $display("FAIL sod0_early_set: got %b want 0", saw_set);
    end
    tsc_1pps = 1'b1;
    #1;
    tests++;
    if ({set, done} !== 2'b11) begin
      fails++;
      $display("FAIL sod0_set_done: got %b want 11", {set, done});
    end
    tests++;
    if (set_time !== 36'h000001000) begin
      fails++;
      $display("FAIL sod0_set_time: got %h want 000001000", set_time);
    end
    cyc();
    tsc_1pps = 1'b0;
    #1;
    tests++;
    if ({busy, set, done} !== 3'b000) begin
      fails++;
      $display("FAIL sod0_after: got %b want 000", {busy, set, done});
    end
  endtask

  task automatic test_load(input string name, input logic [16:0] v, input logic [35:0] exp);
    do_req(v);
    idle_cycles(120);
    tsc_1pps = 1'b1;
    #1;
    tests++;
    if ({set, done, set_time} !== {2'b11, exp}) begin
      fails++;
      $display("FAIL %s: got set/done %b time %h want 11 time %h", name, {set, done},
               set_time, exp);
    end
    cyc();
    tsc_1pps = 1'b0;
  endtask

  task automatic test_range();
    do_req(17'd86400);
    tests++;
    if ({err_range, busy} !== 2'b10) begin
      fails++;
      $display("FAIL range_pulse: got err_range/busy %b want 10", {err_range, busy});
    end
    cyc();
    tests++;
    if ({err_range, busy} !== 2'b00) begin
      fails++;
      $display("FAIL range_after: got err_range/busy %b want 00", {err_range, busy});
    end
    tsc_1pps = 1'b1;
    #1;
    tests++;
    if (set !== 1'b0) begin
      fails++;
      $display("FAIL range_no_set: got %b want 0", set);
    end
    cyc();
    tsc_1pps = 1'b0;
  endtask

  task automatic test_late();
    do_req(17'd86398);
    idle_cycles(4);
    tsc_1pps = 1'b1;
    #1;
    tests++;
    if ({err_late, set, done} !== 3'b100) begin
      fails++;
      $display("FAIL late_pulse: got err_late/set/done %b want 100", {err_late, set, done});
    end
    cyc();
    tsc_1pps = 1'b0;
    #1;
    tests++;
    if ({err_late, busy} !== 2'b00) begin
      fails++;
      $display("FAIL late_after: got err_late/busy %b want 00", {err_late, busy});
    end
    cyc();
    test_load("late_reload", 17'd86398, 36'h235959000);
  endtask

  task automatic test_timeout();
    int  first_to = 0;
    bit  saw_set  = 1'b0;
    do_req(17'd100);
    idle_cycles(120);
    for (int i = 1; i <= 2000; i++) begin
      tsc_1ppms = 1'b1;
      #1;
      if (err_timeout && first_to == 0) first_to = i;
      if (set) saw_set = 1'b1;
      cyc();
      tsc_1ppms = 1'b0;
      cyc();
    end
    tests++;
    if (first_to !== 2000) begin
      fails++;
      $display("FAIL timeout_index: got %0d want 2000", first_to);
    end
    tests++;
    if ({saw_set, busy} !== 2'b00) begin
      fails++;
      $display("FAIL timeout_idle: got set_seen/busy %b want 00", {saw_set, busy});
    end
  endtask

  task automatic test_pps_beats_timeout();
    bit saw_to = 1'b0;
    do_req(17'd100);
    idle_cycles(120);
    for (int i = 1; i < 2000; i++) begin
      tsc_1ppms = 1'b1;
      #1;
      if (err_timeout) saw_to = 1'b1;
      cyc();
      tsc_1ppms = 1'b0;
      cyc();
    end
    tsc_1ppms = 1'b1;
    tsc_1pps  = 1'b1;
    #1;
    if (err_timeout) saw_to = 1'b1;
    tests++;
    if ({set, done, saw_to} !== 3'b110) begin
      fails++;
      $display("FAIL coincide: got set/done/timeout %b want 110", {set, done, saw_to});
    end
    tests++;
    if (set_time !== 36'h000141000) begin
      fails++;
      $display("FAIL coincide_time: got %h want 000141000", set_time);
    end
    cyc();
    tsc_1ppms = 1'b0;
    tsc_1pps  = 1'b0;
  endtask

  task automatic test_req_ignored();
    do_req(17'd45296);
    do_req(17'd0);
    idle_cycles(120);
    tsc_1pps = 1'b1;
    #1;
    tests++;
    if ({set, set_time} !== {1'b1, 36'h123457000}) begin
      fails++;
      $display("FAIL req_ignored: got set %b time %h want 1 time 123457000", set, set_time);
    end
    cyc();
    tsc_1pps = 1'b0;
  endtask

  task automatic test_rst_mid();
    // In MINS after ~20 cycles: 12 hour iterations then 34 minute iterations.
    do_req(17'd45296);
    idle_cycles(20);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    tests++;
    if ({busy, set, done, err_range, err_late, err_timeout, set_time} !== 42'h0) begin
      fails++;
      $display("FAIL rst_mins: got flags %b time %h want 0",
               {busy, set, done, err_range, err_late, err_timeout}, set_time);
    end
    cyc();
    tsc_1pps = 1'b1;
    #1;
    tests++;
    if (set !== 1'b0) begin
      fails++;
      $display("FAIL rst_mins_pps: got %b want 0", set);
    end
    cyc();
    tsc_1pps = 1'b0;

    do_req(17'd0);
    idle_cycles(120);
    tests++;
    if (set_time !== 36'h000001000) begin
      fails++;
      $display("FAIL armed_time: got %h want 000001000", set_time);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    tests++;
    if ({busy, set, done, err_timeout, set_time} !== 40'h0) begin
      fails++;
      $display("FAIL rst_armed: got flags %b time %h want 0",
               {busy, set, done, err_timeout}, set_time);
    end
    cyc();
    tsc_1pps = 1'b1;
    #1;
    tests++;
    if ({set, done} !== 2'b00) begin
      fails++;
      $display("FAIL rst_armed_pps: got %b want 00", {set, done});
    end
    cyc();
    tsc_1pps = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sod0();
    test_load("load_123456", 17'd45296, 36'h123457000);
    test_load("load_wrap", 17'd86399, 36'h000000000);
    test_range();
    test_late();
    test_timeout();
    test_pps_beats_timeout();
    test_req_ignored();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcdtime_load.md
Name: bcdtime_load

Overview:
- Producer side of the bcdtime set interface: drives `set` and `set_time`.
- Accepts a binary seconds-of-day value from the NTP/GPS time-recovery logic and converts it iteratively to BCD `time_t`.
- Arms, then fires `set` exactly on the next `tsc_1pps` so the BCD counters load the new second on the PPS edge.
- Reports range, late-conversion and timeout errors.

Parameters:
- SOD_W, 17, width of the seconds-of-day input.
- TIMEOUT_MS, 2000, number of `tsc_1ppms` pulses allowed in ARMED before abandoning the load.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- tsc_1pps  in  1  one-cycle pulse at each second boundary.
- tsc_1ppms  in  1  one-cycle pulse each millisecond.
- req  in  1  one-cycle request to load `sod`.
- sod  in  SOD_W  seconds-of-day label of the second currently elapsing, 0..86399.
- busy  out  1  high in any state other than IDLE.
- set  out  1  load strobe to bcdtime.
- set_time  out  time_t  BCD load value; nine 4-bit fields t_1ms..t_10h.
- done  out  1  one-cycle pulse, coincident with `set`.
- err_range  out  1  one-cycle pulse: `sod` > 86399.
- err_late  out  1  one-cycle pulse: PPS arrived before conversion finished.
- err_timeout  out  1  one-cycle pulse: no PPS within TIMEOUT_MS.

Behaviour:
- Reset: state IDLE, all outputs 0, `set_time` all fields 0, internal registers cleared. Reset in any state returns to IDLE next cycle with no `set` and no error pulse.
- States: IDLE, HOURS, MINS, SPLIT_H, SPLIT_M, SPLIT_S, ARMED.
- IDLE, `req`=1:
  - If `sod` > 86399: pulse `err_range` the next cycle, stay IDLE.
  - Otherwise latch `v` = `sod`+1, wrapping 86400 to 0, and go to HOURS.
  - `req` is ignored while `busy`=1.
- HOURS: each cycle, if `v` ≥ 3600 then `v` -= 3600 and hour count += 1; else go to MINS.
- MINS: same rule with 60 into the minute count; remainder in `v` is seconds. Go to SPLIT_H.
- SPLIT_H / SPLIT_M / SPLIT_S: repeated subtract-10 of hours, minutes, seconds. Quotient goes to the tens field, remainder to the units field. Advance to the next state when remainder < 10.
- Leaving SPLIT_S: write `set_time` (t_10h, t_1h, t_10m, t_1m, t_10s, t_1s). Force t_100ms, t_10ms, t_1ms = 0. Go to ARMED and clear the ms timeout counter.
- Worst-case conversion: ≤ 100 cycles from `req` to ARMED (23+59+2+5+5 iterations plus transitions).
- Late PPS: `tsc_1pps`=1 in any of HOURS..SPLIT_S aborts. Pulse `err_late`, return to IDLE, no `set`.
- ARMED:
  - `set` = ARMED & `tsc_1pps`, combinational, so it is the same cycle as the PPS pulse.
  - `done` pulses in the same cycle; the next state is IDLE.
  - `set_time` holds its value until the next successful conversion, and is stable before and during `set`.
  - Each `tsc_1ppms` increments the timeout counter. When it reaches TIMEOUT_MS without a PPS: pulse `err_timeout`, go to IDLE.
  - If `tsc_1pps` and the final `tsc_1ppms` coincide, `set` wins and no timeout is reported.
- At most one error or done pulse per request. `busy` deasserts the cycle after `done` or any error.

Test Plan:
- `sod`=0, then PPS 2000 cycles later -> `set`=1 for exactly the PPS cycle; `set_time` = 00:00:01.000 (t_1s=1, all other fields 0); `done` coincident.
- `sod`=45296 (12:34:56) -> at PPS `set_time` = 12:34:57.000 (t_10h=1, t_1h=2, t_10m=3, t_1m=4, t_10s=5, t_1s=7); bcdtime `cur_time` then advances from that value.
- `sod`=86399 -> `set_time` = 00:00:00.000 (wrap); `sod`=86400 -> `err_range` pulse one cycle after `req`, `busy` stays 0, no `set`.
- `req` with `sod`=86398, PPS 5 cycles later -> `err_late`, no `set`; a fresh `req` after that PPS loads 23:59:59.000 at the following PPS.
- ARMED with PPS suppressed and `tsc_1ppms` every 2 cycles -> `err_timeout` after 2000 ms pulses, IDLE, no `set`. Separately, `req` pulsed during HOURS is ignored.
- `rst` asserted in MINS and again in ARMED -> all outputs 0 next cycle; a subsequent PPS produces no `set`.
